ctrl_sequencer: RTL



---
 rtl/ctrl_pkg.sv | 106 ++++++++++
 rtl/imm_extend.sv | 31 +++
 rtl/ctrl_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared encodings for the LEGv8 control sequencer: states,
//               ALU function codes, PC-select codes, opcodes, decode classes
//               and control-word field offsets.
// Revision    : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_EXEC0   = 2'b01,
        S_MEMWAIT = 2'b10,
        S_HALT    = 2'b11
    } state_e;

    typedef enum logic [3:0] {
        CLS_ILL, CLS_ALU_R, CLS_SHIFT, CLS_ALU_I, CLS_LDUR,
        CLS_STUR, CLS_B, CLS_CB, CLS_BCOND
    } cls_e;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_SHAMT, FMT_IMM12, FMT_ADDR9, FMT_IMM26, FMT_IMM19
    } fmt_e;

    localparam logic [4:0] c_fsel_and   = 5'h00;
    localparam logic [4:0] c_fsel_or    = 5'h04;
    localparam logic [4:0] c_fsel_add   = 5'h08;
    localparam logic [4:0] c_fsel_sub   = 5'h09;
    localparam logic [4:0] c_fsel_xor   = 5'h0C;
    localparam logic [4:0] c_fsel_shr   = 5'h10;
    localparam logic [4:0] c_fsel_shl   = 5'h14;
    localparam logic [4:0] c_fsel_passb = 5'h1C;

    localparam logic [1:0] c_psel_hold   = 2'b00;
    localparam logic [1:0] c_psel_pc4    = 2'b01;
    localparam logic [1:0] c_psel_branch = 2'b10;

    localparam logic [10:0] c_op_add   = 11'h458;
    localparam logic [10:0] c_op_sub   = 11'h658;
    localparam logic [10:0] c_op_and   = 11'h450;
    localparam logic [10:0] c_op_orr   = 11'h550;
    localparam logic [10:0] c_op_eor   = 11'h650;
    localparam logic [10:0] c_op_lsl   = 11'h69B;
    localparam logic [10:0] c_op_lsr   = 11'h69A;
    localparam logic [10:0] c_op_ldur  = 11'h7C2;
    localparam logic [10:0] c_op_stur  = 11'h7C0;
    localparam logic [9:0]  c_op_addi  = 10'h244;
    localparam logic [9:0]  c_op_subi  = 10'h344;
    localparam logic [7:0]  c_op_cbz   = 8'hB4;
    localparam logic [7:0]  c_op_cbnz  = 8'hB5;
    localparam logic [7:0]  c_op_bcond = 8'h54;
    localparam logic [5:0]  c_op_b     = 6'h05;

    // Single-bit fields sit below Fsel; register fields stack above it.
    localparam int c_cw_il    = 0;
    localparam int c_cw_sl    = 1;
    localparam int c_cw_pcsel = 2;
    localparam int c_cw_bsel  = 3;
    localparam int c_cw_en_pc = 4;
    localparam int c_cw_en_b  = 5;
    localparam int c_cw_en_alu = 6;
    localparam int c_cw_en_mem = 7;
    localparam int c_cw_ramw  = 8;
    localparam int c_cw_regw  = 9;
    localparam int c_cw_fsel  = 10;
    localparam int c_cw_sb    = 15;

    function automatic int cw_sa_lsb(input int aw);
        return c_cw_sb + aw;
    endfunction

    function automatic int cw_da_lsb(input int aw);
        return c_cw_sb + 2 * aw;
    endfunction

    function automatic int cw_psel_lsb(input int aw);
        return c_cw_sb + 3 * aw;
    endfunction

    // flags are {V,C,N,Z}; codes 14/15 are not taken.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic v, c, n, z;
        {v, c, n, z} = flags;
        case (cond)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return c;
            4'h3:    return !c;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return c && !z;
            4'h9:    return !(c && !z);
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return !(!z && (n == v));
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_extend.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend
// Description : Selects the immediate field of an instruction by format and
//               zero/sign-extends it to DATA_W.
// Revision    : 1.0  initial release
// ============================================================================
module imm_extend
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [31:0]       i_instruction,
    input  logic [2:0]        i_fmt,
    output logic [DATA_W-1:0] o_k
);

    always_comb begin
        o_k = '0;
        case (i_fmt)
            FMT_SHAMT: o_k = DATA_W'(i_instruction[15:10]);
            FMT_IMM12: o_k = DATA_W'(i_instruction[21:10]);
            FMT_ADDR9: o_k = {{(DATA_W-9){i_instruction[20]}}, i_instruction[20:12]};
            FMT_IMM26: o_k = {{(DATA_W-26){i_instruction[25]}}, i_instruction[25:0]};
            FMT_IMM19: o_k = {{(DATA_W-19){i_instruction[23]}}, i_instruction[23:5]};
            default:   o_k = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_sequencer
// Description : Multi-cycle LEGv8 control sequencer with memory-ready
//               timeout and sticky halt. Define CTRL_BCOND_EN to decode B.cond.
// Revision    : 1.0  initial release
// ============================================================================
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instruction,
    input  logic [3:0]            status,
    input  logic                  mem_ready,
    output logic [3*REG_AW+16:0]  controlword,
    output logic [DATA_W-1:0]     K,
    output logic [1:0]            state,
    output logic                  bus_err,
    output logic                  halted
);

`ifdef CTRL_BCOND_EN
    localparam bit c_bcond_en = 1'b1;
`else
    localparam bit c_bcond_en = 1'b0;
`endif

    localparam int c_cnt_w    = $clog2(MEM_TIMEOUT + 1);
    localparam int c_sa_lsb   = cw_sa_lsb(REG_AW);
    localparam int c_da_lsb   = cw_da_lsb(REG_AW);
    localparam int c_psel_lsb = cw_psel_lsb(REG_AW);

    state_e               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_bus_err;
    logic                 r_halted;

    cls_e                 w_cls;
    logic [4:0]           w_fsel;
    logic                 w_sl;
    logic                 w_cond_take;
    fmt_e                 w_fmt;
    logic [3*REG_AW+16:0] w_cw;
    logic [DATA_W-1:0]    w_k;

    assign w_cond_take = cond_holds(instruction[3:0], status);

    always_comb begin
        w_cls  = CLS_ILL;
        w_fsel = c_fsel_and;
        w_sl   = 1'b0;
        case (instruction[31:21])
            c_op_add:  begin w_cls = CLS_ALU_R; w_fsel = c_fsel_add; end
            c_op_sub:  begin w_cls = CLS_ALU_R; w_fsel = c_fsel_sub; w_sl = 1'b1; end
            c_op_and:  begin w_cls = CLS_ALU_R; w_fsel = c_fsel_and; end
            c_op_orr:  begin w_cls = CLS_ALU_R; w_fsel = c_fsel_or;  end
            c_op_eor:  begin w_cls = CLS_ALU_R; w_fsel = c_fsel_xor; end
            c_op_lsl:  begin w_cls = CLS_SHIFT; w_fsel = c_fsel_shl; end
            c_op_lsr:  begin w_cls = CLS_SHIFT; w_fsel = c_fsel_shr; end
            c_op_ldur: begin w_cls = CLS_LDUR;  w_fsel = c_fsel_add; end
            c_op_stur: begin w_cls = CLS_STUR;  w_fsel = c_fsel_add; end
            default: begin
                if (instruction[31:22] == c_op_addi) begin
                    w_cls  = CLS_ALU_I;
                    w_fsel = c_fsel_add;
                end else if (instruction[31:22] == c_op_subi) begin
                    w_cls  = CLS_ALU_I;
                    w_fsel = c_fsel_sub;
                    w_sl   = 1'b1;
                end else if (instruction[31:24] == c_op_cbz ||
                             instruction[31:24] == c_op_cbnz) begin
                    w_cls  = CLS_CB;
                    w_fsel = c_fsel_passb;
                end else if (c_bcond_en && instruction[31:24] == c_op_bcond) begin
                    w_cls  = CLS_BCOND;
                end else if (instruction[31:26] == c_op_b) begin
                    w_cls  = CLS_B;
                end
            end
        endcase
    end

    always_comb begin
        w_cw  = '0;
        w_fmt = FMT_NONE;
        case (r_state)
            S_FETCH: begin
                w_cw[c_cw_il]             = 1'b1;
                w_cw[c_psel_lsb +: 2]     = c_psel_pc4;
            end
            S_EXEC0, S_MEMWAIT: begin
                if (w_cls != CLS_ILL) begin
                    w_cw[c_da_lsb +: REG_AW] = REG_AW'(instruction[4:0]);
                    w_cw[c_sa_lsb +: REG_AW] = REG_AW'(instruction[9:5]);
                    // Stores and compare-branches read the Rt register on the B port.
                    if (w_cls == CLS_STUR || w_cls == CLS_CB)
                        w_cw[c_cw_sb +: REG_AW] = REG_AW'(instruction[4:0]);
                    else
                        w_cw[c_cw_sb +: REG_AW] = REG_AW'(instruction[20:16]);
                    w_cw[c_cw_fsel +: 5] = w_fsel;
                    w_cw[c_cw_sl]        = w_sl;
                end
                case (w_cls)
                    CLS_ALU_R: begin
                        w_cw[c_cw_en_alu] = 1'b1;
                        w_cw[c_cw_regw]   = 1'b1;
                        w_fmt             = FMT_SHAMT;
                    end
                    CLS_SHIFT: begin
                        w_cw[c_cw_en_alu] = 1'b1;
                        w_cw[c_cw_regw]   = 1'b1;
                        w_cw[c_cw_bsel]   = 1'b1;
                        w_fmt             = FMT_SHAMT;
                    end
                    CLS_ALU_I: begin
                        w_cw[c_cw_en_alu] = 1'b1;
                        w_cw[c_cw_regw]   = 1'b1;
                        w_cw[c_cw_bsel]   = 1'b1;
                        w_fmt             = FMT_IMM12;
                    end
                    CLS_LDUR: begin
                        w_cw[c_cw_bsel]    = 1'b1;
                        w_cw[c_cw_en_mem]  = 1'b1;
                        w_cw[c_cw_regw]    = mem_ready;
                        w_fmt              = FMT_ADDR9;
                    end
                    CLS_STUR: begin
                        w_cw[c_cw_bsel]    = 1'b1;
                        w_cw[c_cw_en_mem]  = 1'b1;
                        w_cw[c_cw_ramw]    = 1'b1;
                        w_fmt              = FMT_ADDR9;
                    end
                    CLS_B: begin
                        w_cw[c_psel_lsb +: 2] = c_psel_branch;
                        w_fmt                 = FMT_IMM26;
                    end
                    CLS_CB: begin
                        if (status[0] ^ instruction[24])
                            w_cw[c_psel_lsb +: 2] = c_psel_branch;
                        w_fmt = FMT_IMM19;
                    end
                    CLS_BCOND: begin
                        if (w_cond_take)
                            w_cw[c_psel_lsb +: 2] = c_psel_branch;
                        w_fmt = FMT_IMM19;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    imm_extend #(
        .DATA_W (DATA_W)
    ) u_imm_extend (
        .i_instruction (instruction),
        .i_fmt         (w_fmt),
        .o_k           (w_k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                S_FETCH: r_state <= S_EXEC0;
                S_EXEC0: begin
                    r_cnt <= '0;
                    if (w_cls == CLS_ILL) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if ((w_cls == CLS_LDUR || w_cls == CLS_STUR) && !mem_ready) begin
                        r_state <= S_MEMWAIT;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_MEMWAIT: begin
                    // A ready arriving on the last allowed cycle still completes.
                    if (mem_ready) begin
                        r_state <= S_FETCH;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_w'(MEM_TIMEOUT - 1)) begin
                        r_state   <= S_HALT;
                        r_halted  <= 1'b1;
                        r_bus_err <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    assign controlword = rst_n ? w_cw : '0;
    assign K           = rst_n ? w_k  : '0;
    assign state       = r_state;
    assign bus_err     = r_bus_err;
    assign halted      = r_halted;

endmodule
`default_nettype wire
